// File: rtl/reabastecedor_pkg.sv
// Shared definitions for the cork-tray refill controller.
// FSM state codes, BCD constants and a BCD-to-binary helper.
package reabastecedor_pkg;

    typedef logic [1:0] estado_t;

    localparam estado_t OCIOSO      = 2'd0;
    localparam estado_t ABASTECE    = 2'd1;
    localparam estado_t ESPERA      = 2'd2;
    localparam estado_t SEM_ESTOQUE = 2'd3;

    // One refill batch handed to the tray, in BCD.
    localparam logic [7:0] LOTE     = 8'h20;
    localparam logic [7:0] BCD_MAX  = 8'h99;

    function automatic logic [6:0] bcd_para_bin(input logic [7:0] bcd);
        return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
    endfunction

endpackage

// File: rtl/bcd_soma_sub.sv
// Two-digit BCD add/subtract: resultado = a + soma - subtrai, clamped to 00..99.
// Net result is formed before clamping so a simultaneous add and subtract saturate only once.
import reabastecedor_pkg::*;

module bcd_soma_sub (
    input  logic [7:0] a,
    input  logic [7:0] soma,
    input  logic [7:0] subtrai,
    output logic [7:0] resultado
);

    logic signed [8:0] bruto;
    logic        [6:0] bin;

    always_comb begin
        bruto = $signed({2'b00, bcd_para_bin(a)})
              + $signed({2'b00, bcd_para_bin(soma)})
              - $signed({2'b00, bcd_para_bin(subtrai)});
        if (bruto < 9'sd0) begin
            bin = 7'd0;
        end else if (bruto > $signed({2'b00, bcd_para_bin(BCD_MAX)})) begin
            bin = bcd_para_bin(BCD_MAX);
        end else begin
            bin = bruto[6:0];
        end
        resultado = {4'(bin / 7'd10), 4'(bin % 7'd10)};
    end

endmodule

// File: rtl/reabastecedor.sv
// Cork-tray refill controller: tracks BCD stock and pulses reabastecer per batch of 20.
// Define AUTO_CR_REFILL_EN to also request a refill on a rising edge of CR.
import reabastecedor_pkg::*;

module reabastecedor #(
    parameter logic [7:0] ESTOQUE_INICIAL = 8'h99,
    parameter logic [7:0] REPOSICAO       = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CR,
    input  logic       BZ,
    input  logic       botao,
    input  logic       repor,
    output logic       reabastecer,
    output logic [3:0] unidades_estoque,
    output logic [3:0] dezenas_estoque,
    output logic       EV,
    output logic       ocupado
);

    estado_t    estado, estado_prox;
    logic [7:0] estoque, estoque_prox;
    logic       bz_ant, botao_ant;
    logic       borda_cr;
    logic       pedido;
    logic       tem_lote;
    logic       algum_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado    <= OCIOSO;
            estoque   <= ESTOQUE_INICIAL;
            bz_ant    <= 1'b0;
            botao_ant <= 1'b0;
        end else begin
            estado    <= estado_prox;
            estoque   <= estoque_prox;
            bz_ant    <= BZ;
            botao_ant <= botao;
        end
    end

`ifdef AUTO_CR_REFILL_EN
    logic cr_ant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cr_ant <= 1'b0;
        end else begin
            cr_ant <= CR;
        end
    end

    assign borda_cr = CR & ~cr_ant;
`else
    assign borda_cr = 1'b0;
`endif

    assign pedido     = (BZ & ~bz_ant) | (botao & ~botao_ant) | borda_cr;
    assign tem_lote   = (estoque >= LOTE);
    assign algum_flag = BZ | CR | botao;

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO: begin
                if (pedido) begin
                    estado_prox = tem_lote ? ABASTECE : SEM_ESTOQUE;
                end
            end
            ABASTECE: estado_prox = ESPERA;
            ESPERA: begin
                if (!algum_flag) begin
                    estado_prox = OCIOSO;
                end
            end
            SEM_ESTOQUE: begin
                if (tem_lote && algum_flag) begin
                    estado_prox = ABASTECE;
                end else if (!algum_flag) begin
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // Decrement only happens on the ABASTECE edge, which is entered only with a full batch.
    bcd_soma_sub u_bcd_soma_sub (
        .a         (estoque),
        .soma      (repor ? REPOSICAO : 8'h00),
        .subtrai   (reabastecer ? LOTE : 8'h00),
        .resultado (estoque_prox)
    );

    assign reabastecer      = (estado == ABASTECE);
    assign ocupado          = (estado != OCIOSO);
    assign EV               = (estoque < LOTE);
    assign unidades_estoque = estoque[3:0];
    assign dezenas_estoque  = estoque[7:4];

endmodule

// File: tb/tb_reabastecedor.sv
// Randomized scoreboard bench for reabastecedor against a decimal behavioural model.
// Honours AUTO_CR_REFILL_EN the same way the design does.
module tb_reabastecedor;

    localparam int INICIAL = 99;
    localparam int LOTE_N  = 20;
    localparam int REPOR_N = 10;
`ifdef AUTO_CR_REFILL_EN
    localparam bit CR_EN = 1'b1;
`else
    localparam bit CR_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       CR, BZ, botao, repor;
    logic       reabastecer;
    logic [3:0] unidades_estoque, dezenas_estoque;
    logic       EV, ocupado;

    reabastecedor dut (
        .clk              (clk),
        .reset            (reset),
        .CR               (CR),
        .BZ               (BZ),
        .botao            (botao),
        .repor            (repor),
        .reabastecer      (reabastecer),
        .unidades_estoque (unidades_estoque),
        .dezenas_estoque  (dezenas_estoque),
        .EV               (EV),
        .ocupado          (ocupado)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef enum {M_LIVRE, M_ENTREGA, M_AGUARDA, M_VAZIO} modo_t;

    typedef struct {
        bit pulso;
        int estoque;
        bit ev;
        bit ocup;
    } esperado_t;

    esperado_t fila[$];
    int        n_checks = 0;
    int        n_fail   = 0;

    modo_t modo;
    int    est;
    bit    pbz, pcr, pbot;

    task automatic chk(input string nome, input int atual, input int req);
        n_checks++;
        if (atual != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, req, $time);
        end
    endtask

    // Advance the model across the next clock edge and queue what the outputs must show.
    task automatic passo(input bit em_reset);
        bit        req, flags;
        int        novo;
        esperado_t e;
        if (em_reset) begin
            est  = INICIAL;
            modo = M_LIVRE;
            pbz  = 0;
            pcr  = 0;
            pbot = 0;
        end else begin
            req   = (BZ && !pbz) || (botao && !pbot) || (CR_EN && CR && !pcr);
            flags = BZ || CR || botao;
            novo  = est - ((modo == M_ENTREGA) ? LOTE_N : 0) + (repor ? REPOR_N : 0);
            if (novo > 99) novo = 99;
            if (novo < 0) novo = 0;
            case (modo)
                M_LIVRE:   if (req) modo = (est >= LOTE_N) ? M_ENTREGA : M_VAZIO;
                M_ENTREGA: modo = M_AGUARDA;
                M_AGUARDA: if (!flags) modo = M_LIVRE;
                M_VAZIO: begin
                    if (est >= LOTE_N && flags) modo = M_ENTREGA;
                    else if (!flags) modo = M_LIVRE;
                end
                default: modo = M_LIVRE;
            endcase
            est  = novo;
            pbz  = BZ;
            pcr  = CR;
            pbot = botao;
        end
        e.pulso   = (modo == M_ENTREGA);
        e.estoque = est;
        e.ev      = (est < LOTE_N);
        e.ocup    = (modo != M_LIVRE);
        fila.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, checked shortly after the edge.
    initial begin
        esperado_t e;
        forever begin
            @(posedge clk);
            #2;
            if (fila.size() == 0) begin
                chk("fila_vazia", 0, 1);
            end else begin
                e = fila.pop_front();
                chk("reabastecer", int'(reabastecer), int'(e.pulso));
                chk("estoque", int'(dezenas_estoque) * 10 + int'(unidades_estoque), e.estoque);
                chk("digitos_bcd", int'(unidades_estoque <= 4'd9 && dezenas_estoque <= 4'd9), 1);
                chk("EV", int'(EV), int'(e.ev));
                chk("ocupado", int'(ocupado), int'(e.ocup));
            end
        end
    end

    initial begin
        bit rst_ativo;
        int p_rep, p_flag;
        reset = 1'b0;
        CR    = 1'b0;
        BZ    = 1'b0;
        botao = 1'b0;
        repor = 1'b0;
        est   = INICIAL;
        modo  = M_LIVRE;
        pbz   = 0;
        pcr   = 0;
        pbot  = 0;
        rst_ativo = 1'b1;
        #1;
        chk("reset_reabastecer", int'(reabastecer), 0);
        chk("reset_ocupado", int'(ocupado), 0);
        chk("reset_estoque", int'(dezenas_estoque) * 10 + int'(unidades_estoque), INICIAL);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rst_ativo) begin
                reset     = 1'b1;
                rst_ativo = 1'b0;
            end else if (modo == M_ENTREGA && $urandom_range(0, 99) < 6) begin
                reset = 1'b0;
                #1;
                chk("rst_async_reabastecer", int'(reabastecer), 0);
                chk("rst_async_ocupado", int'(ocupado), 0);
                chk("rst_async_estoque",
                    int'(dezenas_estoque) * 10 + int'(unidades_estoque), INICIAL);
                rst_ativo = 1'b1;
            end
            p_rep  = ((c / 400) % 2 == 1) ? 35 : 4;
            p_flag = 30;
            if ($urandom_range(0, 99) < p_flag) BZ    = ~BZ;
            if ($urandom_range(0, 99) < p_flag) botao = ~botao;
            if ($urandom_range(0, 99) < p_flag) CR    = ~CR;
            repor = ($urandom_range(0, 99) < p_rep);
            // Sustained repor run to exercise saturation at 99.
            if (c >= 1500 && c < 1512) repor = 1'b1;
            passo(!reset);
        end

        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reabastecedor.md
REABASTECEDOR -- requirements
Module: reabastecedor

Interface
REQ-001 The block SHALL have parameter ESTOQUE_INICIAL, default 8'h99, meaning the two-digit BCD stock loaded at reset.
REQ-002 The block SHALL have parameter REPOSICAO, default 8'h10, meaning the two-digit BCD quantity added per repor pulse.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port CR, input, 1 bit, "five corks left" flag from the tray.
REQ-006 The block SHALL have port BZ, input, 1 bit, "tray empty" flag from the tray.
REQ-007 The block SHALL have port botao, input, 1 bit, manual refill request (level, clean, clk-synchronous).
REQ-008 The block SHALL have port repor, input, 1 bit, add REPOSICAO to the stock (level, sampled every cycle).
REQ-009 The block SHALL have port reabastecer, output, 1 bit, one-cycle pulse commanding the tray to add 20 corks.
REQ-010 The block SHALL have ports unidades_estoque and dezenas_estoque, each output, 4 bits, BCD units and tens of the stock.
REQ-011 The block SHALL have port EV, output, 1 bit, meaning stock below 20.
REQ-012 The block SHALL have port ocupado, output, 1 bit, meaning the FSM is not in OCIOSO.

Function
REQ-013 The FSM SHALL use states OCIOSO, ABASTECE, ESPERA and SEM_ESTOQUE.
REQ-014 Request: a rising edge of BZ or botao, or of CR when REQ-030 applies, SHALL be captured; rising edges are detected against the previous-cycle value.
REQ-015 OCIOSO with a request and stock >= 20 SHALL go to ABASTECE; with stock < 20 it SHALL go to SEM_ESTOQUE.
REQ-016 In ABASTECE, reabastecer SHALL be 1 for exactly one cycle, the stock SHALL decrement by 20 on that edge, and the next state SHALL be ESPERA.
REQ-017 reabastecer SHALL be high on the cycle after the request edge is sampled (latency 1).
REQ-018 ESPERA SHALL hold until CR=0 and BZ=0 and botao=0, then go to OCIOSO; requests arriving in ESPERA SHALL be ignored.
REQ-019 SEM_ESTOQUE SHALL go to ABASTECE once stock >= 20 and (BZ=1 or CR=1 or botao=1) are both true; it SHALL go to OCIOSO if all three flags are 0.
REQ-020 Stock arithmetic SHALL be two-digit BCD; each digit SHALL stay in 0..9 at all times.
REQ-021 repor=1 SHALL add REPOSICAO each cycle, saturating at 8'h99.
REQ-022 A simultaneous decrement and repor SHALL apply the net result (stock - 20 + REPOSICAO, then saturate) in one edge.
REQ-023 The stock SHALL never go below 0; a decrement SHALL occur only in ABASTECE, which is entered only with stock >= 20.
REQ-024 EV SHALL be combinational from the stock and SHALL be 1 iff stock < 8'h20.

Reset
REQ-025 While reset=0, the block SHALL set the stock to ESTOQUE_INICIAL, the state to OCIOSO, reabastecer=0, ocupado=0, and clear the edge-detect registers to 0.
REQ-026 The edge-detect registers SHALL clear to 0, so an input already high at reset release SHALL be treated as a rising edge.
REQ-027 Reset asserted mid-ABASTECE SHALL immediately drop reabastecer, with no stock decrement.

Configuration
REQ-028 The block SHALL support macro AUTO_CR_REFILL_EN.
REQ-029 Without AUTO_CR_REFILL_EN, a CR edge SHALL NOT trigger a request; only BZ and botao SHALL trigger.
REQ-030 With AUTO_CR_REFILL_EN defined, a rising edge of CR SHALL also trigger a request (early refill at five corks).

Structure
REQ-031 A shared package SHALL hold the state enum, LOTE=8'h20, and the BCD max constant 8'h99.
REQ-032 A sub-module bcd_soma_sub SHALL implement two-digit BCD add/subtract with saturation at 99 and floor at 0, instantiated once.

Verification
REQ-033 Reset release, ESTOQUE_INICIAL=8'h99, BZ pulses once -> one reabastecer pulse one cycle later; stock 79; ocupado until BZ=0.
REQ-034 Stock 8'h25, botao edge -> pulse, stock 05, EV=1; next BZ edge -> no pulse, SEM_ESTOQUE; repor=1 for 2 cycles with BZ held high -> stock 25 then ABASTECE -> pulse, stock 05.
REQ-035 Stock 8'h95, repor held 3 cycles -> stock 99 (saturated), no digit above 9.
REQ-036 Stock 8'h40, ABASTECE coincides with repor=1 -> stock 30 after that edge.
REQ-037 CR edge with macro off -> no pulse; with AUTO_CR_REFILL_EN -> pulse and stock -20.
REQ-038 Reset asserted in the ABASTECE cycle -> reabastecer low at once, stock = ESTOQUE_INICIAL, state OCIOSO.
